// File: rtl/lc3_mem_pkg.sv
// rtl/lc3_mem_pkg.sv - shared state encoding and defaults for the LC-3 memory access sequencer
package lc3_mem_pkg;

    localparam int TIMEOUT_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MAR    = 3'd1,
        ACCESS = 3'd2,
        LDMDR  = 3'd3,
        DONE   = 3'd4,
        TOUT   = 3'd5
    } state_e;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - control-store request and MARMUX/MAR/MDR/memory strobe bundle
interface mem_access_ctrl_if;

    logic i_Start;
    logic i_Write;
    logic i_Trap;
    logic i_MemR;

    logic o_MarMuxControl;
    logic o_GateMarMux;
    logic o_LdMAR;
    logic o_MemEn;
    logic o_MemWE;
    logic o_LdMDR;
    logic o_Busy;
    logic o_Done;
    logic o_Err;

    modport master (
        output i_Start, i_Write, i_Trap, i_MemR,
        input  o_MarMuxControl, o_GateMarMux, o_LdMAR, o_MemEn, o_MemWE,
        input  o_LdMDR, o_Busy, o_Done, o_Err
    );

    modport slave (
        input  i_Start, i_Write, i_Trap, i_MemR,
        output o_MarMuxControl, o_GateMarMux, o_LdMAR, o_MemEn, o_MemWE,
        output o_LdMDR, o_Busy, o_Done, o_Err
    );

endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - sequences one LC-3 memory access through MARMUX, MAR, memory and MDR
module mem_access_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    mem_access_ctrl_if.slave  bus
);

    localparam int             CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic             write_q, write_d;
    logic             trap_q,  trap_d;
    logic [CW-1:0]    cnt_q,   cnt_d;

    logic mux_sel, gate_mar, ld_mar, mem_en, mem_we, ld_mdr, busy, done, err;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            trap_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            trap_q  <= trap_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        trap_d  = trap_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.i_Start) begin
                    write_d = bus.i_Write;
                    trap_d  = bus.i_Trap;
                    state_d = MAR;
                end
            end
            MAR: state_d = ACCESS;
            ACCESS: begin
                // Ready on the final counted cycle still completes normally.
                if (bus.i_MemR) begin
                    state_d = write_q ? DONE : LDMDR;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = TOUT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            LDMDR: state_d = DONE;
            DONE, TOUT: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mux_sel  = 1'b0;
        gate_mar = 1'b0;
        ld_mar   = 1'b0;
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        ld_mdr   = 1'b0;
        busy     = (state_q != IDLE);
        done     = 1'b0;
        err      = 1'b0;
        case (state_q)
            MAR: begin
                mux_sel  = trap_q;
                gate_mar = 1'b1;
                ld_mar   = 1'b1;
            end
            ACCESS: begin
                mux_sel = trap_q;
                mem_en  = 1'b1;
                mem_we  = write_q;
            end
            LDMDR: begin
                mem_en = 1'b1;
                ld_mdr = 1'b1;
            end
            DONE: done = 1'b1;
            TOUT: begin
                done = 1'b1;
                err  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.o_MarMuxControl = mux_sel;
    assign bus.o_GateMarMux    = gate_mar;
    assign bus.o_LdMAR         = ld_mar;
    assign bus.o_MemEn         = mem_en;
    assign bus.o_MemWE         = mem_we;
    assign bus.o_LdMDR         = ld_mdr;
    assign bus.o_Busy          = busy;
    assign bus.o_Done          = done;
    assign bus.o_Err           = err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl at TIMEOUT 16 and 4
module tb_mem_access_ctrl;

    typedef struct packed {
        logic mux, gate, ldmar, en, we, ldmdr, busy, done, err;
    } outs_t;

    localparam int MAXC = 40;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_access_ctrl_if bus();
    mem_access_ctrl_if bus4();

    assign bus4.i_Start = bus.i_Start;
    assign bus4.i_Write = bus.i_Write;
    assign bus4.i_Trap  = bus.i_Trap;
    assign bus4.i_MemR  = bus.i_MemR;

    mem_access_ctrl #(.TIMEOUT(16)) dut  (.i_Clk(clk), .i_Rst_n(rst_n), .bus(bus.slave));
    mem_access_ctrl #(.TIMEOUT(4))  dut4 (.i_Clk(clk), .i_Rst_n(rst_n), .bus(bus4.slave));

    outs_t obs16, obs4;
    assign obs16 = {bus.o_MarMuxControl, bus.o_GateMarMux, bus.o_LdMAR, bus.o_MemEn, bus.o_MemWE,
                    bus.o_LdMDR, bus.o_Busy, bus.o_Done, bus.o_Err};
    assign obs4  = {bus4.o_MarMuxControl, bus4.o_GateMarMux, bus4.o_LdMAR, bus4.o_MemEn, bus4.o_MemWE,
                    bus4.o_LdMDR, bus4.o_Busy, bus4.o_Done, bus4.o_Err};

    int n_pass  = 0;
    int n_total = 0;
    outs_t got16 [MAXC+1];
    outs_t got4  [MAXC+1];

    // Stand-in for mar_mux + MAR on the bench side.
    logic [15:0] ir, adder, mar;
    always @(posedge clk) if (obs16.ldmar) mar <= obs16.mux ? {8'h00, ir[7:0]} : adder;

    // Cycles from the Start edge until back in IDLE, for a ready arriving in ACCESS cycle d (0-based).
    function automatic int acc_len(int t, bit wr, int d);
        int acc;
        acc = (d < t) ? d + 1 : t;
        if (d >= t) return 1 + acc + 1;
        return 1 + acc + (wr ? 1 : 2);
    endfunction

    function automatic outs_t expect_at(int c, int t, bit wr, bit tr, int d);
        outs_t o;
        int acc, rest;
        o    = '0;
        acc  = (d < t) ? d + 1 : t;
        rest = c - 2 - acc;
        if (c == 1) begin
            o.gate = 1; o.ldmar = 1; o.mux = tr; o.busy = 1;
        end else if (c >= 2 && rest < 0) begin
            o.en = 1; o.we = wr; o.mux = tr; o.busy = 1;
        end else if (d >= t) begin
            if (rest == 0) begin o.busy = 1; o.done = 1; o.err = 1; end
        end else if (!wr && rest == 0) begin
            o.busy = 1; o.en = 1; o.ldmdr = 1;
        end else if (rest == (wr ? 0 : 1)) begin
            o.busy = 1; o.done = 1;
        end
        return o;
    endfunction

    task automatic run_access(input bit wr, input bit tr, input int d, input bit noise, output int ncyc);
        int l16, l4, lmin;
        l16  = acc_len(16, wr, d);
        l4   = acc_len(4, wr, d);
        lmin = (l16 < l4) ? l16 : l4;
        ncyc = ((l16 > l4) ? l16 : l4) + 1;
        @(posedge clk); #1;
        bus.i_Start = 1'b1; bus.i_Write = wr; bus.i_Trap = tr; bus.i_MemR = 1'b0;
        @(posedge clk); #1;
        bus.i_Start = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            bus.i_MemR = (c == 2 + d) || (c == 1 && noise && $urandom_range(0, 1) == 1);
            if (noise) begin
                bus.i_Write = 1'($urandom_range(0, 1));
                bus.i_Trap  = 1'($urandom_range(0, 1));
                bus.i_Start = (c <= lmin) && ($urandom_range(0, 1) == 1);
            end
            @(negedge clk);
            got16[c] = obs16;
            got4[c]  = obs4;
            @(posedge clk); #1;
        end
        bus.i_Start = 1'b0; bus.i_MemR = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.i_Start = 1'b1; bus.i_Write = 1'b1; bus.i_Trap = 1'b1; bus.i_MemR = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if (obs16 !== '0 || obs4 !== '0) $display("FAIL reset_outputs got %b/%b expected all zero", obs16, obs4);
        else n_pass++;
        bus.i_Start = 1'b0; bus.i_MemR = 1'b0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (obs16 !== '0 || obs4 !== '0) $display("FAIL idle_after_reset got %b/%b expected all zero", obs16, obs4);
        else n_pass++;
    endtask

    task automatic test_read;
        int n;
        adder = 16'($urandom);
        run_access(1'b0, 1'b0, 0, 1'b0, n);
        for (int c = 1; c <= n; c++) begin
            n_total += 2;
            if (got16[c] !== expect_at(c, 16, 0, 0, 0)) $display("FAIL read c%0d got %b expected %b", c, got16[c], expect_at(c, 16, 0, 0, 0));
            else n_pass++;
            if (got4[c] !== expect_at(c, 4, 0, 0, 0)) $display("FAIL read_t4 c%0d got %b expected %b", c, got4[c], expect_at(c, 4, 0, 0, 0));
            else n_pass++;
        end
        n_total++;
        if (mar !== adder) $display("FAIL read_mar got %h expected %h", mar, adder);
        else n_pass++;
    endtask

    task automatic test_trap;
        int n;
        ir    = {8'($urandom), 8'h25};
        adder = 16'hBEEF;
        run_access(1'b0, 1'b1, 3, 1'b0, n);
        for (int c = 1; c <= n; c++) begin
            n_total += 2;
            if (got16[c] !== expect_at(c, 16, 0, 1, 3)) $display("FAIL trap c%0d got %b expected %b", c, got16[c], expect_at(c, 16, 0, 1, 3));
            else n_pass++;
            if (got4[c] !== expect_at(c, 4, 0, 1, 3)) $display("FAIL trap_t4_edge c%0d got %b expected %b", c, got4[c], expect_at(c, 4, 0, 1, 3));
            else n_pass++;
        end
        n_total++;
        if (mar !== 16'h0025) $display("FAIL trap_mar got %h expected 0025", mar);
        else n_pass++;
    endtask

    task automatic test_write;
        int n, we_cnt;
        we_cnt = 0;
        run_access(1'b1, 1'b0, 2, 1'b0, n);
        for (int c = 1; c <= n; c++) begin
            we_cnt += int'(got16[c].we);
            n_total += 2;
            if (got16[c] !== expect_at(c, 16, 1, 0, 2)) $display("FAIL write c%0d got %b expected %b", c, got16[c], expect_at(c, 16, 1, 0, 2));
            else n_pass++;
            if (got4[c] !== expect_at(c, 4, 1, 0, 2)) $display("FAIL write_t4 c%0d got %b expected %b", c, got4[c], expect_at(c, 4, 1, 0, 2));
            else n_pass++;
        end
        n_total++;
        if (we_cnt != 3) $display("FAIL write_we_cycles got %0d expected 3", we_cnt);
        else n_pass++;
    endtask

    task automatic test_timeout;
        int n;
        int ds [4] = '{6, 0, 15, 16};
        bit ws [4] = '{0, 0, 1, 0};
        foreach (ds[i]) begin
            run_access(ws[i], 1'b0, ds[i], 1'b0, n);
            for (int c = 1; c <= n; c++) begin
                n_total += 2;
                if (got16[c] !== expect_at(c, 16, ws[i], 0, ds[i]))
                    $display("FAIL timeout d%0d c%0d got %b expected %b", ds[i], c, got16[c], expect_at(c, 16, ws[i], 0, ds[i]));
                else n_pass++;
                if (got4[c] !== expect_at(c, 4, ws[i], 0, ds[i]))
                    $display("FAIL timeout_t4 d%0d c%0d got %b expected %b", ds[i], c, got4[c], expect_at(c, 4, ws[i], 0, ds[i]));
                else n_pass++;
            end
        end
    endtask

    task automatic test_start_ignored;
        int n, dones;
        bit wr;
        for (int k = 0; k < 4; k++) begin
            wr = k[0];
            dones = 0;
            run_access(wr, 1'b0, k, 1'b1, n);
            for (int c = 1; c <= n; c++) begin
                dones += int'(got16[c].done);
                n_total++;
                if (got16[c] !== expect_at(c, 16, wr, 0, k)) $display("FAIL start_ignored c%0d got %b expected %b", c, got16[c], expect_at(c, 16, wr, 0, k));
                else n_pass++;
            end
            n_total++;
            if (dones != 1) $display("FAIL start_ignored_dones got %0d expected 1", dones);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_access;
        int n;
        @(posedge clk); #1;
        bus.i_Start = 1'b1; bus.i_Write = 1'b1; bus.i_Trap = 1'b1; bus.i_MemR = 1'b0;
        @(posedge clk); #1;
        bus.i_Start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        n_total++;
        if (!obs16.en || !obs16.we) $display("FAIL pre_reset_access got %b expected memory strobes", obs16);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (obs16 !== '0 || obs4 !== '0) $display("FAIL async_reset got %b/%b expected all zero", obs16, obs4);
        else n_pass++;
        #1 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_total++;
            if (obs16 !== '0 || obs4 !== '0) $display("FAIL post_reset_idle c%0d got %b/%b expected all zero", c, obs16, obs4);
            else n_pass++;
        end
        run_access(1'b0, 1'b0, 1, 1'b0, n);
        for (int c = 1; c <= n; c++) begin
            n_total++;
            if (got16[c] !== expect_at(c, 16, 0, 0, 1)) $display("FAIL after_reset_read c%0d got %b expected %b", c, got16[c], expect_at(c, 16, 0, 0, 1));
            else n_pass++;
        end
    endtask

    task automatic test_random;
        int n, d;
        bit wr, tr, nz;
        for (int k = 0; k < 25; k++) begin
            wr = 1'($urandom_range(0, 1));
            tr = 1'($urandom_range(0, 1));
            nz = 1'($urandom_range(0, 1));
            d  = $urandom_range(0, 17);
            run_access(wr, tr, d, nz, n);
            for (int c = 1; c <= n; c++) begin
                n_total += 2;
                if (got16[c] !== expect_at(c, 16, wr, tr, d))
                    $display("FAIL random k%0d c%0d got %b expected %b", k, c, got16[c], expect_at(c, 16, wr, tr, d));
                else n_pass++;
                if (got4[c] !== expect_at(c, 4, wr, tr, d))
                    $display("FAIL random_t4 k%0d c%0d got %b expected %b", k, c, got4[c], expect_at(c, 4, wr, tr, d));
                else n_pass++;
            end
        end
    endtask

    initial begin
        ir = 16'h0000; adder = 16'h3000;
        test_reset;
        test_read;
        test_trap;
        test_write;
        test_timeout;
        test_start_ignored;
        test_reset_mid_access;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
